// File: rtl/vga_pkg.sv
// Shared framebuffer constants and clear-engine state type.
package vga_pkg;
    localparam int ADDR_W_DEF   = 17;
    localparam int DATA_W_DEF   = 15;
    localparam int FB_DEPTH_DEF = 76800;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;
endpackage

// File: rtl/vga_fb_clear.sv
// Framebuffer clear engine: sweeps 0..FB_DEPTH-1 writing a latched colour
// whenever the arbiter grants it a cycle.
module vga_fb_clear
    import vga_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FB_DEPTH = FB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] colour,
    input  logic              grant,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] colour_q;
    logic              done_q;
    logic              last_wr;

    assign last_wr = (state == CLR_CLEAR) && grant && (addr_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CLR_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLR_IDLE:  if (start)   state_nxt = CLR_CLEAR;
            CLR_CLEAR: if (last_wr) state_nxt = CLR_IDLE;
            default:                state_nxt = CLR_IDLE;
        endcase
    end

    // The address parks on the last word instead of wrapping; start re-zeroes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            colour_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_wr;
            if (state == CLR_IDLE && start) begin
                addr_q   <= '0;
                colour_q <= colour;
            end else if (state == CLR_CLEAR && grant && !last_wr) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign wr_req  = (state == CLR_CLEAR);
    assign busy    = (state == CLR_CLEAR);
    assign wr_addr = addr_q;
    assign wr_data = colour_q;
    assign done    = done_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out > clear > drawing engine.
// Clear engine is built only when VGA_FB_CLEAR_EN is defined.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FB_DEPTH = FB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_ack,
    output logic              draw_rvalid,
    output logic              draw_err,
    output logic [DATA_W-1:0] draw_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_colour,
    output logic              clear_busy,
    output logic              clear_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    logic              clr_req, clr_gnt, clr_hold;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic              scan_gnt;
    logic              rd_err;
    logic [ADDR_W-1:0] last_addr;

`ifdef VGA_FB_CLEAR_EN
    vga_fb_clear #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(FB_DEPTH)) u_clear (
        .clk     (clk),
        .reset   (reset),
        .start   (clear_start),
        .colour  (clear_colour),
        .grant   (clr_gnt),
        .wr_req  (clr_req),
        .wr_addr (clr_addr),
        .wr_data (clr_data),
        .busy    (clear_busy),
        .done    (clear_done)
    );
    // The start cycle already belongs to the clear engine, so draw waits then too.
    assign clr_hold = clear_busy | clear_start;
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_colour};
    assign clr_req      = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
    assign clear_busy   = 1'b0;
    assign clear_done   = 1'b0;
    assign clr_hold     = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the RAM while held in reset.
    always_comb begin
        scan_gnt  = reset & scan_req;
        clr_gnt   = reset & clr_req & ~scan_req;
        draw_ack  = reset & draw_req & ~scan_req & ~clr_hold;
        draw_err  = draw_ack & (draw_addr > LAST);
        mem_addr  = last_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (scan_gnt) begin
            mem_addr = scan_addr;
        end else if (clr_gnt) begin
            mem_addr  = clr_addr;
            mem_we    = 1'b1;
            mem_wdata = clr_data;
        end else if (draw_ack) begin
            mem_addr  = draw_addr;
            mem_we    = draw_we & ~draw_err;
            mem_wdata = draw_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_valid  <= 1'b0;
            draw_rvalid <= 1'b0;
            rd_err      <= 1'b0;
            last_addr   <= '0;
        end else begin
            scan_valid  <= scan_gnt;
            draw_rvalid <= draw_ack & ~draw_we;
            rd_err      <= draw_err & ~draw_we;
            last_addr   <= mem_addr;
        end
    end

    assign scan_data  = scan_valid ? mem_rdata : '0;
    assign draw_rdata = (draw_rvalid && !rd_err) ? mem_rdata : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter; clear tests run when VGA_FB_CLEAR_EN is defined.
module tb_vga_fb_arbiter;
    localparam int AW = 17;
    localparam int DW = 15;
    localparam int FB_DEPTH = 76800;

    logic          clk, reset;
    logic          scan_req, scan_valid;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic          draw_req, draw_we, draw_ack, draw_rvalid, draw_err;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_wdata, draw_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          clear_start, clear_busy, clear_done;
    logic [DW-1:0] clear_colour;

    int checks = 0;
    int failures = 0;

    // RAM behind the arbiter and the bench's own view of what it should hold.
    logic [DW-1:0] ram     [0:(1<<AW)-1] = '{100: 15'h7C00, 76800: 15'h1234, default: '0};
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{100: 15'h7C00, 76800: 15'h1234, default: '0};

    logic          exp_sv, exp_rv;
    logic [DW-1:0] exp_sd, exp_rd;
    logic [AW-1:0] m_last;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(FB_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .draw_ack(draw_ack), .draw_rvalid(draw_rvalid), .draw_err(draw_err), .draw_rdata(draw_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return AW'($urandom_range(0, 15));
        else if (r < 9) return AW'(FB_DEPTH + $urandom_range(0, 3));
        else            return AW'((1 << AW) - 1);
    endfunction

    // One arbitration cycle checked against the priority/latency rules (no clear activity).
    task automatic cycle();
        logic          e_ack, e_err, e_we;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        chk("scan_valid", 32'(scan_valid), 32'(exp_sv));
        if (exp_sv) chk("scan_data", 32'(scan_data), 32'(exp_sd));
        chk("draw_rvalid", 32'(draw_rvalid), 32'(exp_rv));
        if (exp_rv) chk("draw_rdata", 32'(draw_rdata), 32'(exp_rd));
        e_ack = draw_req && !scan_req;
        e_err = e_ack && (int'(draw_addr) >= FB_DEPTH);
        e_we  = e_ack && draw_we && !e_err;
        chk("draw_ack", 32'(draw_ack), 32'(e_ack));
        chk("draw_err", 32'(draw_err), 32'(e_err));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (scan_req)   e_addr = scan_addr;
        else if (e_ack) e_addr = draw_addr;
        else            e_addr = m_last;
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(draw_wdata));
        m_last = e_addr;
        exp_sv = scan_req;
        exp_sd = ref_mem[scan_addr];
        exp_rv = e_ack && !draw_we;
        exp_rd = e_err ? '0 : ref_mem[draw_addr];
        if (e_we) ref_mem[draw_addr] = draw_wdata;
        @(posedge clk); #1;
        if (e_ack) draw_req = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt, ack_bad, bad_words;
        bit acked, hit;

        reset = 1'b0; scan_req = 1'b1; scan_addr = 17'd3;
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'd4; draw_wdata = 15'h1111;
        clear_start = 1'b1; clear_colour = 15'h001F;
        exp_sv = 1'b0; exp_rv = 1'b0; exp_sd = '0; exp_rd = '0; m_last = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scan_valid", 32'(scan_valid), 0);
        chk("rst_scan_data", 32'(scan_data), 0);
        chk("rst_draw_rvalid", 32'(draw_rvalid), 0);
        chk("rst_draw_err", 32'(draw_err), 0);
        chk("rst_draw_rdata", 32'(draw_rdata), 0);
        chk("rst_clear_busy", 32'(clear_busy), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        scan_req = 1'b0; draw_req = 1'b0; clear_start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Scan read of a preloaded word returns one cycle later.
        scan_req = 1'b1; scan_addr = 17'd100;
        cycle();
        scan_req = 1'b0;
        chk("scan100_valid", 32'(scan_valid), 1);
        chk("scan100_data", 32'(scan_data), 32'h7C00);
        cycle();

        // Draw write then read-back of address 5.
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'd5; draw_wdata = 15'h03E0;
        #1;
        chk("wr5_ack", 32'(draw_ack), 1);
        chk("wr5_we", 32'(mem_we), 1);
        chk("wr5_addr", 32'(mem_addr), 5);
        cycle();
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = 17'd5;
        cycle();
        chk("rd5_rvalid", 32'(draw_rvalid), 1);
        chk("rd5_rdata", 32'(draw_rdata), 32'h03E0);

        // Scan held for 10 cycles starves a pending draw read.
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = 17'd100;
        scan_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            scan_addr = AW'($urandom_range(0, 15));
            #1;
            chk("starve_ack", 32'(draw_ack), 0);
            cycle();
        end
        scan_req = 1'b0;
        #1;
        chk("starve_release_ack", 32'(draw_ack), 1);
        cycle();

        // Idle cycle: no write, address held at last granted value.
        #1;
        chk("idle_we", 32'(mem_we), 0);
        chk("idle_addr_hold", 32'(mem_addr), 100);
        cycle();

        // Out-of-range write and read.
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'd76800; draw_wdata = 15'h7FFF;
        #1;
        chk("oor_wr_ack", 32'(draw_ack), 1);
        chk("oor_wr_err", 32'(draw_err), 1);
        chk("oor_wr_we", 32'(mem_we), 0);
        cycle();
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = 17'd76800;
        cycle();
        chk("oor_rd_rvalid", 32'(draw_rvalid), 1);
        chk("oor_rd_rdata", 32'(draw_rdata), 0);
        chk("oor_ram_untouched", 32'(ram[76800]), 32'h1234);

`ifndef VGA_FB_CLEAR_EN
        // Without the clear engine, clear_start is inert and draw is served.
        clear_start = 1'b1; clear_colour = 15'h001F;
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'd7; draw_wdata = 15'h0AAA;
        #1;
        chk("noclr_ack", 32'(draw_ack), 1);
        chk("noclr_busy", 32'(clear_busy), 0);
        cycle();
        clear_start = 1'b0;
        cycle();
        chk("noclr_busy_after", 32'(clear_busy), 0);
        chk("noclr_done", 32'(clear_done), 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            scan_req  = ($urandom_range(0, 2) == 0);
            scan_addr = rand_addr();
            if (!draw_req && $urandom_range(0, 1) == 1) begin
                draw_req   = 1'b1;
                draw_we    = 1'($urandom_range(0, 1));
                draw_addr  = rand_addr();
                draw_wdata = DW'($urandom);
            end
            cycle();
        end
        scan_req = 1'b0;
        cycle();
        cycle();

`ifdef VGA_FB_CLEAR_EN
        // Full clear with a draw read waiting the whole time.
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = 17'd9;
        clear_start = 1'b1; clear_colour = 15'h001F;
        #1;
        chk("clr_start_ack", 32'(draw_ack), 0);
        @(posedge clk); #1;
        clear_start = 1'b0; clear_colour = 15'h7FFF;
        busy_cnt = 0; done_cnt = 0; ack_bad = 0; acked = 0;
        for (int i = 0; i < 80000 && !acked; i++) begin
            @(negedge clk);
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (draw_ack && clear_busy) ack_bad++;
            if (draw_ack) acked = 1;
            @(posedge clk); #1;
        end
        draw_req = 1'b0;
        chk("clr_draw_served", 32'(acked), 1);
        chk("clr_rd_rvalid", 32'(draw_rvalid), 1);
        chk("clr_rd_rdata", 32'(draw_rdata), 32'h001F);
        chk("clr_busy_cycles", 32'(busy_cnt), 32'(FB_DEPTH));
        chk("clr_done_pulses", 32'(done_cnt), 1);
        chk("clr_ack_during_busy", 32'(ack_bad), 0);
        bad_words = 0;
        for (int a = 0; a < FB_DEPTH; a++) if (ram[a] !== 15'h001F) bad_words++;
        chk("clr_ram_words_bad", 32'(bad_words), 0);

        // Abort at address 1000 by reset, then restart from 0.
        clear_start = 1'b1; clear_colour = 15'h0155;
        @(posedge clk); #1;
        clear_start = 1'b0;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 17'd1000) hit = 1;
        end
        chk("abort_reached_1000", 32'(hit), 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(clear_busy), 0);
        chk("abort_we", 32'(mem_we), 0);
        done_cnt = 0;
        repeat (3) begin @(negedge clk); if (clear_done) done_cnt++; end
        reset = 1'b1;
        repeat (3) begin @(negedge clk); if (clear_done || clear_busy) done_cnt++; end
        chk("abort_no_done", 32'(done_cnt), 0);
        @(posedge clk); #1;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        chk("restart_busy", 32'(clear_busy), 1);
        chk("restart_we", 32'(mem_we), 1);
        chk("restart_addr", 32'(mem_addr), 0);
        chk("restart_colour", 32'(mem_wdata), 32'h0155);
        reset = 1'b0;
        #1;
        chk("final_rst_busy", 32'(clear_busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
